// File: rtl/buf_seq_ctrl_pkg.sv
// Shared definitions for the fill/drain buffer sequencer.
//   state_t   : sequencer states (IDLE, FILL, DRAIN)
//   WIDTH_DEF : default data bits per buffer entry
//   DEPTH_DEF : default number of buffer entries (power of two, >= 2)
package buf_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/buf_seq_ctrl_if.sv
// Handshake bundle between a producer/consumer and buf_seq_ctrl.
//   start, abort           : transaction control (master -> slave)
//   in_valid, in_data      : fill stream (master -> slave)
//   in_ready               : high while filling (slave -> master)
//   out_valid, out_data    : drain stream (slave -> master)
//   out_ready              : consumer accept (master -> slave)
//   busy, done, level      : status (slave -> master)
interface buf_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    logic                     start;
    logic                     abort;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready;
    logic                     busy;
    logic                     done;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output start, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done, level
    );

    modport slave (
        input  start, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done, level
    );
endinterface

// File: rtl/buf_seq_ctrl_regfile.sv
// Buffer storage for buf_seq_ctrl: one synchronous write port, one
// asynchronous read port, and all entries cleared by the async reset.
//   clk, rstn      : clock, asynchronous active-low reset
//   we, waddr, wdata : write port
//   raddr, rdata   : combinational read port
module buf_regfile #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/buf_seq_ctrl.sv
// Fill/drain buffer sequencer. A start pulse begins a transaction that
// accepts DEPTH valid samples, then replays them in order to the consumer,
// pulsing done for one cycle after the last beat. abort cancels at any time.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : handshake bundle (slave side), see buf_seq_ctrl_if
module buf_seq_ctrl
    import buf_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    buf_seq_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we;
    logic [WIDTH-1:0] rd_data;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        done_d   = 1'b0;
        we       = 1'b0;

        if (bus.abort) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d  = ST_FILL;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        level_d  = '0;
                    end
                end
                ST_FILL: begin
                    if (bus.in_valid) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        level_d  = level_q + LVL_W'(1);
                        if (level_q == LVL_W'(DEPTH - 1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // out_valid is high throughout DRAIN, so out_ready alone
                    // marks an accepted beat.
                    if (bus.out_ready) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        level_d  = level_q - LVL_W'(1);
                        if (level_q == LVL_W'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    level_d  = '0;
                end
            endcase
        end

        // Status flags are registered from the next state so they line up
        // with state_q without extra decode on the output.
        in_ready_d  = (state_d == ST_FILL);
        out_valid_d = (state_d == ST_DRAIN);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    buf_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = rd_data;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.level     = level_q;
endmodule

// File: tb/tb_buf_seq_ctrl.sv
// Directed bench for buf_seq_ctrl (WIDTH=4, DEPTH=8). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_buf_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [WIDTH-1:0] exp_buf [DEPTH];

    always #5 clk = ~clk;

    buf_seq_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    buf_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_done"}, 32'(bus.done), 0);
        check_eq({tag, "_level"}, 32'(bus.level), 0);
    endtask

    // Fill DEPTH valid beats with values base, base+1, ...; with gaps the
    // in_valid pattern is 1,0,1,1,0,1,1,0,... and start is held high to show
    // it is ignored while filling.
    task automatic do_fill(input logic [WIDTH-1:0] base, input logic gaps);
        int   n = 0;
        int   c = 0;
        logic v;
        while (n < DEPTH && c < 40) begin
            v = gaps ? (c % 3 != 1) : 1'b1;
            bus.start    = gaps;
            bus.in_valid = v;
            bus.in_data  = v ? WIDTH'(base + n) : 4'h5;
            if (v) exp_buf[n] = bus.in_data;
            @(negedge clk);
            if (v) n++;
            c++;
            check_eq("fill_level", 32'(bus.level), 32'(n));
            check_eq("fill_in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
            check_eq("fill_out_valid", 32'(bus.out_valid), 32'(n == DEPTH));
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("fill_beats", 32'(n), DEPTH);
    endtask

    // Drain nbeats; out_ready is held low for stall_len cycles before beat
    // stall_at. in_valid is held high with junk data to show it is ignored.
    task automatic do_drain(input int nbeats, input int stall_at, input int stall_len);
        int k = 0;
        int stalled = 0;
        int cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h3;
        while (k < nbeats && cyc < 40) begin
            check_eq("drain_out_valid", 32'(bus.out_valid), 1);
            check_eq("drain_out_data", 32'(bus.out_data), 32'(exp_buf[k]));
            check_eq("drain_level", 32'(bus.level), 32'(DEPTH - k));
            check_eq("drain_done", 32'(bus.done), 0);
            bus.out_ready = !(k == stall_at && stalled < stall_len);
            @(negedge clk);
            if (bus.out_ready) k++;
            else stalled++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("drain_beats", 32'(k), 32'(nbeats));
        if (nbeats == DEPTH) begin
            check_eq("end_done", 32'(bus.done), 1);
            check_eq("end_busy", 32'(bus.busy), 0);
            check_eq("end_out_valid", 32'(bus.out_valid), 0);
            check_eq("end_level", 32'(bus.level), 0);
            @(negedge clk);
            check_eq("done_one_cycle", 32'(bus.done), 0);
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_idle("rst");
        check_eq("rst_out_data", 32'(bus.out_data), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset mid-FILL after 3 writes
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("start_in_ready", 32'(bus.in_ready), 1);
        check_eq("start_busy", 32'(bus.busy), 1);
        check_eq("start_level", 32'(bus.level), 0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'(9 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check_eq("pre_rst_level", 32'(bus.level), 3);
        #2 rstn = 1'b0;
        #1;
        check_idle("midfill_rst");
        check_eq("midfill_rst_out_data", 32'(bus.out_data), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_idle("post_rst");
        check_eq("post_rst_out_data", 32'(bus.out_data), 0);

        // Back-to-back fill 1..8 and drain with out_ready held high
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("t2_in_ready", 32'(bus.in_ready), 1);
        do_fill(4'd1, 1'b0);
        do_drain(DEPTH, -1, 0);

        // Gapped fill with start held; drain stalled 3 cycles before beat 2
        bus.start = 1'b1;
        @(negedge clk);
        do_fill(4'd7, 1'b1);
        do_drain(DEPTH, 2, 3);

        // Abort at level 5 in DRAIN with out_ready and start also high
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        do_fill(4'd2, 1'b0);
        do_drain(3, -1, 0);
        check_eq("pre_abort_level", 32'(bus.level), 5);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        check_idle("abort_drain");
        check_eq("abort_kept_data", 32'(bus.out_data), 2);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("restart_in_ready", 32'(bus.in_ready), 1);
        check_eq("restart_level", 32'(bus.level), 0);
        check_eq("restart_done", 32'(bus.done), 0);

        // Abort in FILL with in_valid high: no write beyond the first beat
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        @(negedge clk);
        check_eq("abort_fill_pre_level", 32'(bus.level), 1);
        bus.abort   = 1'b1;
        bus.in_data = 4'd14;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_idle("abort_fill");
        check_eq("abort_fill_out_data", 32'(bus.out_data), 1);

        // abort beats start in IDLE
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_idle("abort_vs_start");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/buf_seq_ctrl.md
BUF_SEQ_CTRL -- requirements
Module: buf_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per buffer entry.
REQ-002 SHALL have parameter DEPTH, default 8, number of buffer entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a pulse that begins a fill/drain transaction.
REQ-006 SHALL have port abort, input, 1, which cancels any transaction in progress.
REQ-007 SHALL have port in_valid, input, 1, which qualifies in_data.
REQ-008 SHALL have port in_data, input, WIDTH, the sample to store.
REQ-009 SHALL have port in_ready, output, 1, high only in FILL.
REQ-010 SHALL have port out_valid, output, 1, high only in DRAIN.
REQ-011 SHALL have port out_data, output, WIDTH, equal to buffer[rd_ptr].
REQ-012 SHALL have port out_ready, input, 1, the consumer accept signal.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse after the last drain beat.
REQ-015 SHALL have port level, output, $clog2(DEPTH)+1, the count of entries written and not yet drained.

Function
REQ-016 SHALL implement states IDLE, FILL and DRAIN.
REQ-017 IDLE -> FILL on the rising edge where start=1 and abort=0; wr_ptr, rd_ptr and level SHALL clear to 0 on that edge.
REQ-018 In FILL, on each edge with in_valid=1, buffer[wr_ptr] SHALL take in_data, and wr_ptr and level SHALL each increment by 1.
REQ-019 The in_valid=1 beat that makes level==DEPTH SHALL move FILL -> DRAIN on the same edge, with wr_ptr wrapping to 0.
REQ-020 In DRAIN, each out_valid&&out_ready edge SHALL increment rd_ptr and decrement level.
REQ-021 The DRAIN beat that makes level==0 SHALL move DRAIN -> IDLE, with done=1 for exactly the next cycle.
REQ-022 Drain order SHALL equal fill order, entry 0 first.
REQ-023 out_data SHALL be combinational from the buffer at rd_ptr, giving zero added latency; out_data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge and clear the pointers and level; buffer contents SHALL be kept, and done SHALL NOT pulse.
REQ-025 abort SHALL have priority over start, in_valid and out_ready in the same cycle.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 in_valid outside FILL and out_ready outside DRAIN SHALL be ignored, with no write and no pointer change.
REQ-028 Pointer arithmetic SHALL be modulo DEPTH; level SHALL never exceed DEPTH or go below 0.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE, clear wr_ptr, rd_ptr and level to 0, and clear every buffer entry to 0.
REQ-030 During reset, in_ready, out_valid, busy and done SHALL be 0, and out_data SHALL be 0.
REQ-031 Reset asserted mid-FILL or mid-DRAIN SHALL discard the transaction with no done pulse.

Structure
REQ-032 A shared package buf_seq_pkg SHALL hold the state enum, WIDTH_DEF=4 and DEPTH_DEF=8.
REQ-033 Storage SHALL be one sub-module, buf_regfile, with one write port, one asynchronous read port and async-clear of all entries.
REQ-034 The FSM, pointers and level logic SHALL live in buf_seq_ctrl.

Verification
REQ-035 Reset mid-FILL after 3 writes: all outputs 0, level=0, state IDLE, and a later drain of a new fill shows no stale data.
REQ-036 start, then in_valid held for 8 cycles with in_data 1..8, out_ready=1: out_data 1..8 on consecutive cycles, done pulses once, busy falls with it.
REQ-037 Fill with gaps (in_valid pattern 1,0,1,1,0,...): only valid beats are stored, level tracks them, and DRAIN is entered only after the 8th valid beat.
REQ-038 DRAIN with out_ready low for 3 cycles: out_data and level hold, then draining resumes in order.
REQ-039 abort at level=5 in DRAIN together with out_ready=1: next state IDLE, level=0, no done pulse; start the following cycle begins a fresh FILL.
REQ-040 start asserted during FILL and in_valid asserted during DRAIN: no effect on the pointers, level or data.
